// File: rtl/uart_pkg.sv
// Shared types and parity helper for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  localparam int MAX_DATA_W = 9;

  // Mode 2'b11 is reserved and behaves like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Callers zero-extend the data word to MAX_DATA_W; extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: clock-enable pulse every div+1 clocks, realigned by restart.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  assign tick = (r_cnt == {DIV_W{1'b0}});

  // Down-counter; restart loads div so the first tick lands div+1 clocks later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {DIV_W{1'b0}};
    end else if (restart || tick) begin
      r_cnt <= div;
    end else begin
      r_cnt <= r_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with runtime baud divisor, parity mode and stop-bit count.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the frame FSM.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int SUB_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       IDX_LAST = 4'(DATA_W - 1);

  tx_state_e             r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_shift, w_shift_nxt, r_data_q, w_start_data;
  logic [3:0]            r_idx, w_idx_nxt;
  logic [SUB_W-1:0]      r_sub;
  logic [DIV_W-1:0]      r_div_q, w_div;
  logic [1:0]            r_par_q;
  logic                  r_stop2_q, r_txd, w_txd_nxt, w_done;
  logic                  w_tick, w_bit_end, w_start, w_par_bit;
  logic [MAX_DATA_W-1:0] w_par_vec;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_count;
  logic              w_full, w_empty, w_push;

  assign w_full       = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty      = (r_count == {(PTR_W+1){1'b0}});
  assign tx_ready     = !reset && !w_full;
  assign w_push       = tx_valid && tx_ready && en;
  assign w_start      = (r_state == IDLE) && !w_empty && en;
  assign w_start_data = r_fifo[r_rptr];
  assign tx_busy      = (r_state != IDLE) || !w_empty;

  // FIFO pointers and occupancy; a pop is the frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {(PTR_W+1){1'b0}};
    end else begin
      r_wptr <= w_push  ? r_wptr + {{(PTR_W-1){1'b0}}, 1'b1} : r_wptr;
      r_rptr <= w_start ? r_rptr + {{(PTR_W-1){1'b0}}, 1'b1} : r_rptr;
      case ({w_push, w_start})
        2'b10:   r_count <= r_count + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{PTR_W{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= tx_data;
    end
  end
`else
  assign tx_ready     = !reset && en && (r_state == IDLE);
  assign w_start      = tx_valid && tx_ready;
  assign w_start_data = tx_data;
  assign tx_busy      = (r_state != IDLE);
`endif

  // The divisor presented at a frame start must reach the generator in the same edge.
  assign w_div = w_start ? baud_div : r_div_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (w_start),
    .div     (w_div),
    .tick    (w_tick)
  );

  assign w_bit_end = w_tick && (r_sub == SUB_LAST);
  assign txd       = r_txd;
  assign tx_done   = w_done;

  // Sub-bit counter, realigned to zero at every frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sub <= {SUB_W{1'b0}};
    end else if (w_start) begin
      r_sub <= {SUB_W{1'b0}};
    end else if (w_tick) begin
      r_sub <= (r_sub == SUB_LAST) ? {SUB_W{1'b0}} : r_sub + {{(SUB_W-1){1'b0}}, 1'b1};
    end else begin
      r_sub <= r_sub;
    end
  end

  // Frame configuration snapshot taken at the frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_q   <= {DIV_W{1'b0}};
      r_par_q   <= PAR_NONE;
      r_stop2_q <= 1'b0;
      r_data_q  <= {DATA_W{1'b0}};
    end else if (w_start) begin
      r_div_q   <= baud_div;
      r_par_q   <= parity_mode;
      r_stop2_q <= stop2;
      r_data_q  <= w_start_data;
    end else begin
      r_div_q   <= r_div_q;
      r_par_q   <= r_par_q;
      r_stop2_q <= r_stop2_q;
      r_data_q  <= r_data_q;
    end
  end

  // Parity over the captured word.
  always_comb begin
    w_par_vec               = {MAX_DATA_W{1'b0}};
    w_par_vec[DATA_W-1:0]   = r_data_q;
    w_par_bit               = parity_bit(w_par_vec, r_par_q);
  end

  // Next-state, shift/index and next txd level; txd is registered from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_done      = 1'b0;
    w_txd_nxt   = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = START;
          w_shift_nxt = w_start_data;
          w_idx_nxt   = 4'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 4'd0;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          if (r_idx == IDX_LAST) begin
            w_state_nxt = parity_enabled(r_par_q) ? PARITY : STOP;
            w_idx_nxt   = 4'd0;
          end else begin
            w_idx_nxt   = r_idx + 4'd1;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_idx_nxt   = 4'd0;
        end else begin
          w_state_nxt = PARITY;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_idx == {3'b000, r_stop2_q}) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 4'd1;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      PARITY:  w_txd_nxt = w_par_bit;
      STOP:    w_txd_nxt = 1'b1;
      IDLE:    w_txd_nxt = 1'b1;
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // FSM and line registers; reset drives the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= {DATA_W{1'b0}};
      r_idx   <= 4'd0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: frame-level reference model plus directed literal checks.
module tb_uart_tx_param;

  localparam int OS    = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] baud_div = 16'd1;
  logic [1:0]  parity_mode = 2'b01;
  logic        stop2 = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, txd, tx_busy, tx_done;

  uart_tx_param #(.DATA_W(8), .OVERSAMPLE(OS), .DIV_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .txd(txd), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a frame is a list of bit levels, each lasting (div+1)*OS clocks.
  bit         m_active = 1'b0;
  int         m_t = 0, m_T = 1, m_len = 0, m_nbits = 0;
  bit         m_bits[16];
  int         m_acc_cnt = 0, m_start_cnt = 0, m_start_cyc = 0;
  logic [7:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic m_begin(input logic [7:0] d, input logic [15:0] div, input logic [1:0] pm, input logic s2);
    int n;
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[1+i] = d[i];
    n = 9;
    if (pm == 2'b01) begin m_bits[n] = ^d; n++; end
    else if (pm == 2'b10) begin m_bits[n] = ~^d; n++; end
    m_bits[n] = 1'b1; n++;
    if (s2) begin m_bits[n] = 1'b1; n++; end
    m_nbits = n;
    m_T = (int'(div) + 1) * OS;
    m_len = n * m_T;
    m_t = 0;
    m_active = 1'b1;
    m_start_cyc = cyc;
    m_start_cnt++;
  endtask

  always @(posedge clk) begin
    bit was_active;
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      q.delete();
    end else begin
      was_active = m_active;
`ifdef UART_TX_FIFO_EN
      begin
        int pre_n;
        pre_n = q.size();
        if (m_active) begin m_t++; if (m_t == m_len) m_active = 1'b0; end
        if (!was_active && pre_n > 0 && en) m_begin(q.pop_front(), baud_div, parity_mode, stop2);
        if (tx_valid && en && pre_n < DEPTH) begin q.push_back(tx_data); m_acc_cnt++; end
      end
`else
      if (m_active) begin m_t++; if (m_t == m_len) m_active = 1'b0; end
      if (!was_active && en && tx_valid) begin
        m_begin(tx_data, baud_div, parity_mode, stop2);
        m_acc_cnt++;
      end
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic e_txd, e_busy, e_done, e_ready;
    e_busy = !reset && (m_active || q.size() != 0);
    e_txd  = (reset || !m_active) ? 1'b1 : m_bits[m_t / m_T];
    e_done = !reset && m_active && (m_t == m_len - 1);
`ifdef UART_TX_FIFO_EN
    e_ready = !reset && (q.size() < DEPTH);
`else
    e_ready = !reset && en && !m_active;
`endif
    chk("txd", txd, e_txd);
    chk("tx_busy", tx_busy, e_busy);
    chk("tx_done", tx_done, e_done);
    chk("tx_ready", tx_ready, e_ready);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic at_k(input int k);
    while (cyc < m_start_cyc + k) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] div, input logic [1:0] pm, input logic s2);
    int a0, s0, guard;
    a0 = m_acc_cnt; s0 = m_start_cnt; guard = 0;
    tx_data = d; baud_div = div; parity_mode = pm; stop2 = s2; tx_valid = 1'b1;
    while (m_acc_cnt == a0 && guard < 5000) begin step(1); guard++; end
    tx_valid = 1'b0;
    while (m_start_cnt == s0 && guard < 5000) begin step(1); guard++; end
    chk("frame_start_timeout", (guard < 5000), 1'b1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((m_active || q.size() != 0) && guard < 5000) begin step(1); guard++; end
    chk("idle_timeout", (guard < 5000), 1'b1);
    step(2);
  endtask

  initial begin
    logic [10:0] a5_exp;
    int a1, s0, guard;
    a5_exp = 11'b10101001010;

    repeat (3) @(posedge clk);
    #3;
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_ready", tx_ready, 1'b0);
    en = 1'b1;
    #1;
    chk("rst_ready_en", tx_ready, 1'b0);
    step(1);
    reset = 1'b0;
    step(2);

    // 0xA5 even parity, T=32
    send(8'hA5, 16'd1, 2'b01, 1'b0);
    chk("a5_len", m_len, 352);
    for (int b = 0; b < 11; b++) begin
      at_k(b * 32 + 16);
      chk("a5_bit", txd, a5_exp[b]);
    end
    at_k(351);
    chk("a5_done", tx_done, 1'b1);
    chk("a5_busy", tx_busy, 1'b1);
    at_k(352);
    chk("a5_done_end", tx_done, 1'b0);
    chk("a5_busy_end", tx_busy, 1'b0);

    // Parity variants of 0x07
    send(8'h07, 16'd1, 2'b10, 1'b0);
    at_k(9 * 32 + 16);
    chk("odd_par_07", txd, 1'b0);
    wait_idle();
    send(8'h07, 16'd1, 2'b01, 1'b0);
    at_k(9 * 32 + 16);
    chk("even_par_07", txd, 1'b1);
    wait_idle();
    send(8'h07, 16'd1, 2'b11, 1'b0);
    chk("par11_len", m_len, 320);
    at_k(319);
    chk("par11_done", tx_done, 1'b1);
    at_k(320);
    chk("par11_idle", tx_busy, 1'b0);

    // Two stop bits, no parity, baud_div=0
    send(8'hC3, 16'd0, 2'b00, 1'b1);
    at_k(152);
    chk("stop2_bit9", txd, 1'b1);
    at_k(168);
    chk("stop2_bit10", txd, 1'b1);
    at_k(175);
    chk("stop2_done", tx_done, 1'b1);
    at_k(176);
    chk("stop2_idle", tx_busy, 1'b0);

    // Config changes mid-frame do not disturb the current frame
    send(8'h5A, 16'd1, 2'b00, 1'b0);
    at_k(100);
    baud_div = 16'd5;
    parity_mode = 2'b10;
    at_k(319);
    chk("midcfg_done", tx_done, 1'b1);
    wait_idle();
    send(8'h5A, 16'd5, 2'b10, 1'b0);
    at_k(9 * 96 + 48);
    chk("t96_par", txd, 1'b1);
    at_k(1055);
    chk("t96_done", tx_done, 1'b1);
    wait_idle();

    // Reset mid-frame at a zero bit
    send(8'hFB, 16'd1, 2'b01, 1'b0);
    at_k(100);
    chk("pre_rst_txd", txd, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1'b1);
    chk("async_rst_busy", tx_busy, 1'b0);
    step(3);
    reset = 1'b0;
    step(2);
    send(8'h3C, 16'd1, 2'b01, 1'b0);
    at_k(9 * 32 + 16);
    chk("3c_par", txd, 1'b0);
    at_k(351);
    chk("3c_done", tx_done, 1'b1);
    wait_idle();

    // Back-to-back: one idle clock between frames
    send(8'h81, 16'd0, 2'b00, 1'b0);
    a1 = m_start_cyc;
    send(8'h7E, 16'd0, 2'b00, 1'b0);
    chk("b2b_gap", m_start_cyc - a1, 161);
    wait_idle();

`ifndef UART_TX_FIFO_EN
    // en dropped mid-frame: frame completes, no new acceptance
    send(8'h96, 16'd1, 2'b00, 1'b0);
    at_k(50);
    en = 1'b0;
    tx_valid = 1'b1;
    at_k(320);
    chk("en_off_idle", tx_busy, 1'b0);
    step(10);
    chk("en_off_ready", tx_ready, 1'b0);
    tx_valid = 1'b0;
    step(1);
    en = 1'b1;
    step(2);
`else
    // FIFO: five consecutive pushes, the last fills the queue
    baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
    tx_valid = 1'b1;
    s0 = m_start_cnt;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'(8'h11 * (i + 1));
      chk("fifo_ready", tx_ready, 1'b1);
      step(1);
    end
    tx_data = 8'h66;
    chk("fifo_full", tx_ready, 1'b0);
    tx_valid = 1'b0;
    guard = 0;
    while (m_start_cnt == s0 && guard < 100) begin step(1); guard++; end
    for (int f = 0; f < 4; f++) begin
      s0 = m_start_cnt;
      a1 = m_start_cyc;
      guard = 0;
      while (m_start_cnt == s0 && guard < 1000) begin step(1); guard++; end
      chk("fifo_gap", m_start_cyc - a1, 161);
    end
    wait_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
